// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - read-side drain controller for the fifo block
//
// Purpose:
//   Pops words from the upstream FIFO whenever it is non-empty and local
//   space exists. Absorbs the FIFO's one-cycle read latency in a small
//   circular output buffer and re-presents the words on a valid/ready stream.
//   Keeps a sticky record of FIFO read errors.
//
// Optional feature macro: DRAIN_POP_COUNT_EN (adds pop_count port/counter).
//
// Ports:
//   clk            in   clock, all logic on posedge
//   reset          in   synchronous, active-high
//   drain_en       in   1 = allow reads from the FIFO
//   Fifo_empty     in   FIFO empty flag
//   Fifo_Data_out  in   FIFO read data, valid the cycle after Fifo_rd
//   Fifo_rd_error  in   FIFO read-underflow flag
//   ready_in       in   downstream accepts data_out this cycle
//   Fifo_rd        out  FIFO pop strobe
//   data_out       out  head of output buffer (0 when empty)
//   valid_out      out  data_out holds a word
//   idle           out  IDLE state, nothing in flight, buffer empty
//   rd_err_sticky  out  sticky record of Fifo_rd_error
//   pop_count      out  words accepted downstream (DRAIN_POP_COUNT_EN only)

module fifo_drain_ctrl #(
  parameter int BITNUMBER = 8,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 drain_en,
  input  logic                 Fifo_empty,
  input  logic [BITNUMBER-1:0] Fifo_Data_out,
  input  logic                 Fifo_rd_error,
  input  logic                 ready_in,
  output logic                 Fifo_rd,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 valid_out,
  output logic                 idle,
  output logic                 rd_err_sticky
`ifdef DRAIN_POP_COUNT_EN
  ,
  output logic [CNT_W-1:0]     pop_count
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam logic [1:0] LAST_PTR  = 2'(BUF_DEPTH - 1);
  localparam logic [3:0] DEPTH_CMP = 4'(BUF_DEPTH);

  if (BUF_DEPTH < 2 || BUF_DEPTH > 4 || CNT_W < 1) begin : g_bad_param
    $error("fifo_drain_ctrl: BUF_DEPTH must be 2..4 and CNT_W >= 1");
  end

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 r_inflight;
  logic [2:0]           r_occ;
  logic [1:0]           r_wr_ptr;
  logic [1:0]           r_rd_ptr;
  logic                 r_rd_err;
  // Storage is sized for the largest legal depth; pointers wrap at BUF_DEPTH.
  logic [BITNUMBER-1:0] r_buf [0:3];

  logic                 w_valid;
  logic                 w_pop;
  logic [3:0]           w_occ_net;
  logic                 w_fifo_rd;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_valid = (r_occ != 3'd0);
  assign w_pop   = w_valid && ready_in;

  // Space check counts the word already in flight and credits a word leaving
  // this cycle, so a full buffer being drained still pops every cycle.
  assign w_occ_net = {1'b0, r_occ} + {3'b000, r_inflight} - {3'b000, w_pop};
  assign w_fifo_rd = (r_state == ST_RUN) && !Fifo_empty && (w_occ_net < DEPTH_CMP);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (drain_en) w_state_nxt = ST_RUN;
      ST_RUN:  if (!drain_en) w_state_nxt = ST_STOP;
      ST_STOP: begin
        if (drain_en) begin
          w_state_nxt = ST_RUN;
        end else if (!r_inflight && r_occ == 3'd0) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_inflight <= 1'b0;
      r_occ      <= 3'd0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_rd_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_fifo_rd;
      if (r_inflight) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)      r_rd_ptr <= next_ptr(r_rd_ptr);
      r_occ <= r_occ + {2'b00, r_inflight} - {2'b00, w_pop};
      if (Fifo_rd_error) r_rd_err <= 1'b1;
    end
  end

  // Data path needs no reset: only entries covered by r_occ are ever shown.
  // A read in flight at reset is dropped because r_inflight clears.
  always_ff @(posedge clk) begin
    if (!reset && r_inflight) begin
      r_buf[r_wr_ptr] <= Fifo_Data_out;
    end
  end

  assign Fifo_rd       = w_fifo_rd;
  assign valid_out     = w_valid;
  assign data_out      = w_valid ? r_buf[r_rd_ptr] : '0;
  assign idle          = (r_state == ST_IDLE) && !r_inflight && (r_occ == 3'd0);
  assign rd_err_sticky = r_rd_err;

`ifdef DRAIN_POP_COUNT_EN
  logic [CNT_W-1:0] r_pop_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pop_count <= '0;
    end else if (w_pop) begin
      r_pop_count <= r_pop_count + 1'b1;
    end
  end

  assign pop_count = r_pop_count;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - self-checking bench for fifo_drain_ctrl

module tb_fifo_drain_ctrl;

  localparam int BD = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       drain_en;
  logic       Fifo_empty;
  logic [7:0] Fifo_Data_out;
  logic       Fifo_rd_error;
  logic       ready_in;
  logic       Fifo_rd;
  logic [7:0] data_out;
  logic       valid_out;
  logic       idle;
  logic       rd_err_sticky;
`ifdef DRAIN_POP_COUNT_EN
  logic [15:0] pop_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] got[$];
  bit         rd_s = 1'b0;
  int         occ_m = 0;
  int         infl_m = 0;
  int         rd_pulses = 0;

  fifo_drain_ctrl #(.BITNUMBER(8), .BUF_DEPTH(BD), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .drain_en      (drain_en),
    .Fifo_empty    (Fifo_empty),
    .Fifo_Data_out (Fifo_Data_out),
    .Fifo_rd_error (Fifo_rd_error),
    .ready_in      (ready_in),
    .Fifo_rd       (Fifo_rd),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .idle          (idle),
    .rd_err_sticky (rd_err_sticky)
`ifdef DRAIN_POP_COUNT_EN
    ,
    .pop_count     (pop_count)
`endif
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: one-cycle read latency, empty flag follows contents.
  always @(posedge clk) begin
    #1;
    if (rd_s && q.size() > 0) Fifo_Data_out = q.pop_front();
    Fifo_empty = (q.size() == 0);
  end

  // Cycle monitor: occupancy model and protocol invariants.
  always @(negedge clk) begin
    rd_s = Fifo_rd;
    if (Fifo_rd) rd_pulses++;
    checks++;
    if (Fifo_rd === 1'b1 && Fifo_empty === 1'b1) begin
      errors++;
      $display("FAIL mon_rd_while_empty got Fifo_rd=1 exp 0 at %0t", $time);
    end
    checks++;
    if (infl_m == 1 && occ_m == BD && !(valid_out && ready_in)) begin
      errors++;
      $display("FAIL mon_capture_into_full got occ=%0d inflight=1 at %0t", occ_m, $time);
    end
    checks++;
    if (valid_out !== (occ_m != 0)) begin
      errors++;
      $display("FAIL mon_valid got %b exp %b at %0t", valid_out, (occ_m != 0), $time);
    end
    if (reset) begin
      occ_m  = 0;
      infl_m = 0;
    end else begin
      occ_m  = occ_m + infl_m - ((valid_out && ready_in) ? 1 : 0);
      infl_m = Fifo_rd ? 1 : 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] w);
    q.push_back(w);
    Fifo_empty = 1'b0;
  endtask

  task automatic clear_fifo;
    q.delete();
    Fifo_empty = 1'b1;
  endtask

  // Collect accepted words for n cycles; starts at posedge+1, ends at posedge+1.
  task automatic collect(input int n);
    got.delete();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (valid_out && ready_in) got.push_back(data_out);
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    load(8'h01); load(8'h02); load(8'h03);
    tick();
    @(negedge clk);
    checks++;
    if (idle !== 1'b1 || valid_out !== 1'b0 || Fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got idle=%b valid=%b rd=%b exp 1 0 0", idle, valid_out, Fifo_rd);
    end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (Fifo_rd !== 1'b0 || idle !== 1'b1 || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_drain k=%0d got rd=%b idle=%b valid=%b exp 0 1 0", k, Fifo_rd, idle, valid_out);
      end
      if (k == 0) begin
        checks++;
        if (data_out !== 8'h00 || rd_err_sticky !== 1'b0) begin
          errors++;
          $display("FAIL reset_values got data=%h sticky=%b exp 00 0", data_out, rd_err_sticky);
        end
      end
      tick();
    end
    clear_fifo();
  endtask

  task automatic test_stream;
    bit         exp_rd [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
    bit         exp_vl [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    logic [7:0] exp_d  [8] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    drain_en = 1'b1;
    ready_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (Fifo_rd !== exp_rd[k] || valid_out !== exp_vl[k]) begin
        errors++;
        $display("FAIL stream_ctl k=%0d got rd=%b valid=%b exp %b %b", k, Fifo_rd, valid_out, exp_rd[k], exp_vl[k]);
      end
      if (exp_vl[k]) begin
        checks++;
        if (data_out !== exp_d[k]) begin
          errors++;
          $display("FAIL stream_data k=%0d got %h exp %h", k, data_out, exp_d[k]);
        end
      end
`ifdef DRAIN_POP_COUNT_EN
      if (k == 7) begin
        checks++;
        if (pop_count !== 16'd4) begin
          errors++;
          $display("FAIL stream_pop_count got %0d exp 4", pop_count);
        end
      end
`endif
      tick();
    end
  endtask

  task automatic test_backpressure;
    bit exp_rd [6] = '{1, 1, 0, 0, 0, 0};
    bit exp_vl [6] = '{0, 0, 1, 1, 1, 1};
    ready_in = 1'b0;
    rd_pulses = 0;
    for (int i = 1; i <= 6; i++) load(8'hA0 + 8'(i));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (Fifo_rd !== exp_rd[k] || valid_out !== exp_vl[k]) begin
        errors++;
        $display("FAIL bp_ctl k=%0d got rd=%b valid=%b exp %b %b", k, Fifo_rd, valid_out, exp_rd[k], exp_vl[k]);
      end
      if (exp_vl[k]) begin
        checks++;
        if (data_out !== 8'hA1) begin
          errors++;
          $display("FAIL bp_head_hold k=%0d got %h exp a1", k, data_out);
        end
      end
      tick();
    end
    ready_in = 1'b1;
    collect(20);
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL bp_resume_count got %0d exp 6", got.size());
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++;
      if (got[i] !== 8'hA1 + 8'(i)) begin
        errors++;
        $display("FAIL bp_resume_data i=%0d got %h exp %h", i, got[i], 8'hA1 + 8'(i));
      end
    end
    checks++;
    if (rd_pulses != 6) begin
      errors++;
      $display("FAIL bp_rd_pulses got %0d exp 6", rd_pulses);
    end
  endtask

  task automatic test_stop_inflight;
    bit exp_rd [5] = '{1, 0, 0, 0, 0};
    bit exp_vl [5] = '{0, 0, 1, 0, 0};
    bit exp_id [5] = '{0, 0, 0, 0, 1};
    load(8'hB1); load(8'hB2);
    drain_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (Fifo_rd !== exp_rd[k] || valid_out !== exp_vl[k] || idle !== exp_id[k]) begin
        errors++;
        $display("FAIL stop_ctl k=%0d got rd=%b valid=%b idle=%b exp %b %b %b",
                 k, Fifo_rd, valid_out, idle, exp_rd[k], exp_vl[k], exp_id[k]);
      end
      if (exp_vl[k]) begin
        checks++;
        if (data_out !== 8'hB1) begin
          errors++;
          $display("FAIL stop_inflight_data got %h exp b1", data_out);
        end
      end
      tick();
    end
    clear_fifo();
  endtask

  task automatic test_empty_and_error;
    drain_en = 1'b1;
    ready_in = 1'b1;
    load(8'hC1); load(8'hC2);
    got.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid_out && ready_in) got.push_back(data_out);
      tick();
      if (c == 8) load(8'hC3);
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL gap_count got %0d exp 3", got.size());
    end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      checks++;
      if (got[i] !== 8'hC1 + 8'(i)) begin
        errors++;
        $display("FAIL gap_data i=%0d got %h exp %h", i, got[i], 8'hC1 + 8'(i));
      end
    end
    Fifo_rd_error = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL err_before got %b exp 0", rd_err_sticky);
    end
    tick();
    Fifo_rd_error = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (rd_err_sticky !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky k=%0d got %b exp 1", k, rd_err_sticky);
      end
      tick();
    end
  endtask

  task automatic test_reset_inflight;
    load(8'hD1); load(8'hD2); load(8'hD3); load(8'hD4);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'hD1 || Fifo_rd !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got valid=%b data=%h rd=%b exp 1 d1 1", valid_out, data_out, Fifo_rd);
    end
    tick();
    reset = 1'b0;
    drain_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || Fifo_rd !== 1'b0 || idle !== 1'b1 || data_out !== 8'h00) begin
        errors++;
        $display("FAIL rst_post k=%0d got valid=%b rd=%b idle=%b data=%h exp 0 0 1 00",
                 k, valid_out, Fifo_rd, idle, data_out);
      end
      if (k == 0) begin
        checks++;
        if (rd_err_sticky !== 1'b0) begin
          errors++;
          $display("FAIL rst_sticky_clear got %b exp 0", rd_err_sticky);
        end
`ifdef DRAIN_POP_COUNT_EN
        checks++;
        if (pop_count !== 16'd0) begin
          errors++;
          $display("FAIL rst_pop_count got %0d exp 0", pop_count);
        end
`endif
      end
      tick();
    end
    drain_en = 1'b1;
    collect(15);
    checks++;
    if (got.size() != 1 || got[0] !== 8'hD4) begin
      errors++;
      $display("FAIL rst_discard got n=%0d first=%h exp n=1 d4", got.size(), (got.size() > 0) ? got[0] : 8'h00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    drain_en      = 1'b0;
    ready_in      = 1'b0;
    Fifo_rd_error = 1'b0;
    Fifo_empty    = 1'b1;
    Fifo_Data_out = 8'h00;
    tick();
    test_reset();
    test_stream();
    test_backpressure();
    test_stop_inflight();
    test_empty_and_error();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
